// File: rtl/avalon_data_master_if.sv
// Avalon-MM data bus between the core-side initiator and a waitrequest-capable slave.
interface avalon_data_master_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/avalon_data_master.sv
// Core load/store -> Avalon-MM initiator; min 3 cycles (accept, bus, done), stall held until done.
// Slave backpressure via waitrequest holds the strobe; TIMEOUT consecutive waits aborts with err.
module avalon_data_master #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  err,
  avalon_data_master_if.master  avm
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [3:0]      be_q, be_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            illegal;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     rd_ext;

  assign avm.avm_address    = addr_q;
  assign avm.avm_read       = rd_q;
  assign avm.avm_write      = wr_q;
  assign avm.avm_byteenable = be_q;
  assign avm.avm_writedata  = wdat_q;
  assign done               = done_q;
  assign err                = err_q;
  assign rdata              = rdata_q;
  assign stall              = (req_read | req_write) & ~done_q;

  assign illegal = (req_read & req_write)
                 | (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (|req_addr[1:0]));

  // Lane select uses the offset latched at accept, not the live request.
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = avm.avm_readdata[7:0];
      2'd1:    rd_byte = avm.avm_readdata[15:8];
      2'd2:    rd_byte = avm.avm_readdata[23:16];
      default: rd_byte = avm.avm_readdata[31:24];
    endcase
    rd_half = off_q[1] ? avm.avm_readdata[31:16] : avm.avm_readdata[15:0];
    case (size_q)
      2'b00:   rd_ext = {{24{sgn_q & rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{16{sgn_q & rd_half[15]}}, rd_half};
      default: rd_ext = avm.avm_readdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    off_d   = off_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_read | req_write) begin
          if (illegal) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            addr_d  = {req_addr[31:2], 2'b00};
            off_d   = req_addr[1:0];
            size_d  = req_size;
            sgn_d   = req_signed;
            cnt_d   = '0;
            rd_d    = req_read;
            wr_d    = req_write;
            state_d = req_read ? READ : WRITE;
            case (req_size)
              2'b00:   be_d = 4'b0001 << req_addr[1:0];
              2'b01:   be_d = req_addr[1] ? 4'b1100 : 4'b0011;
              default: be_d = 4'b1111;
            endcase
            case (req_size)
              2'b00:   wdat_d = {4{req_wdata[7:0]}};
              2'b01:   wdat_d = {2{req_wdata[15:0]}};
              default: wdat_d = req_wdata;
            endcase
          end
        end
      end
      READ, WRITE: begin
        if (!avm.avm_waitrequest) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
          if (state_q == READ) rdata_d = rd_ext;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_avalon_data_master.sv
// Bench for avalon_data_master: directed table, reset corner cases, randomized accesses vs. reference model.
module tb_avalon_data_master;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_read, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        stall, done, err;
  logic [31:0] rdata;

  avalon_data_master_if bus ();

  avalon_data_master #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
    .stall(stall), .done(done), .rdata(rdata), .err(err),
    .avm(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          ncyc;
    int          nstrobe;
    int          nstall;
    logic        e;
    logic [31:0] rdat;
    logic [3:0]  be;
    logic [31:0] ad;
    logic [31:0] wdo;
    logic        done_after;
  } res_t;

  typedef struct {
    logic        rd, wr;
    logic [31:0] a, wd;
    logic [1:0]  sz;
    logic        sg;
    int          waits;
    logic [31:0] rdv;
    logic [31:0] e_rdata;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    logic        e_err;
    int          e_strb;
  } vec_t;

  typedef struct {
    logic        legal;
    logic        err;
    int          strobes;
    logic [3:0]  be;
    logic [31:0] addr, wd, rd;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One complete request: slave holds waitrequest for the first `waits` strobe cycles.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sg, input int waits,
                        input logic [31:0] rdv, output res_t r);
    bit fin;
    r = '{default: 0};
    fin = 0;
    @(negedge clk);
    req_read = rd; req_write = wr; req_addr = a; req_wdata = wd;
    req_size = sz; req_signed = sg;
    bus.avm_readdata = rdv; bus.avm_waitrequest = 1'b1;
    r.ncyc = 1;
    #1 if (stall) r.nstall++;
    while (!fin && r.ncyc < 40) begin
      @(negedge clk);
      r.ncyc++;
      if (stall) r.nstall++;
      if (bus.avm_read | bus.avm_write) begin
        r.nstrobe++;
        r.be  = bus.avm_byteenable;
        r.ad  = bus.avm_address;
        r.wdo = bus.avm_writedata;
        bus.avm_waitrequest = (r.nstrobe <= waits);
      end
      if (done) begin
        fin = 1;
        r.e = err;
        r.rdat = rdata;
        req_read = 1'b0; req_write = 1'b0;
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL done_wait actual=no_done required=done_within_40");
      req_read = 1'b0; req_write = 1'b0;
    end
    @(negedge clk);
    r.done_after = done;
  endtask

  function automatic exp_t model(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                                 input int waits, input logic [31:0] rdv);
    exp_t x;
    int nb;
    int off;
    logic [31:0] v, mask;
    nb  = (sz == 2'd3) ? 4 : (1 << sz);
    off = int'(a % 4);
    x.legal   = (rd != wr) && (sz != 2'd3) && ((a % nb) == 0);
    x.err     = !x.legal || (waits >= TIMEOUT);
    x.strobes = !x.legal ? 0 : ((waits >= TIMEOUT) ? TIMEOUT : waits + 1);
    x.be      = 4'(((1 << nb) - 1) << off);
    x.addr    = a - 32'(off);
    for (int i = 0; i < 4; i++) x.wd[8*i +: 8] = wd[8*(i % nb) +: 8];
    v    = rdv >> (8 * off);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v    = v & mask;
    if (sg && nb < 4 && v[8*nb-1]) v = v | ~mask;
    x.rd = v;
    return x;
  endfunction

  vec_t        tbl[10];
  res_t        r;
  exp_t        x;
  logic [31:0] last_rd;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 0,   32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 32'h10, 32'h0,        1'b0, 1};
    tbl[1] = '{1'b1, 1'b0, 32'h13, 32'h0,        2'd0, 1'b1, 0,   32'h80112233, 32'hFFFFFF80, 4'h8, 32'h10, 32'h0,        1'b0, 1};
    tbl[2] = '{1'b1, 1'b0, 32'h13, 32'h0,        2'd0, 1'b0, 0,   32'h80112233, 32'h00000080, 4'h8, 32'h10, 32'h0,        1'b0, 1};
    tbl[3] = '{1'b0, 1'b1, 32'h22, 32'h0000ABCD, 2'd1, 1'b0, 4,   32'h0,        32'h00000080, 4'hC, 32'h20, 32'hABCDABCD, 1'b0, 5};
    tbl[4] = '{1'b1, 1'b0, 32'h06, 32'h0,        2'd2, 1'b0, 0,   32'h12345678, 32'h00000080, 4'h0, 32'h0,  32'h0,        1'b1, 0};
    tbl[5] = '{1'b1, 1'b0, 32'h00, 32'h0,        2'd3, 1'b0, 0,   32'h12345678, 32'h00000080, 4'h0, 32'h0,  32'h0,        1'b1, 0};
    tbl[6] = '{1'b1, 1'b0, 32'h40, 32'h0,        2'd2, 1'b0, 100, 32'h12345678, 32'h00000080, 4'hF, 32'h40, 32'h0,        1'b1, 8};
    tbl[7] = '{1'b1, 1'b0, 32'h02, 32'h0,        2'd1, 1'b1, 0,   32'h80011234, 32'hFFFF8001, 4'hC, 32'h0,  32'h0,        1'b0, 1};
    tbl[8] = '{1'b0, 1'b1, 32'h01, 32'h123456A5, 2'd0, 1'b0, 2,   32'h0,        32'hFFFF8001, 4'h2, 32'h0,  32'hA5A5A5A5, 1'b0, 3};
    tbl[9] = '{1'b1, 1'b1, 32'h08, 32'h0,        2'd2, 1'b0, 0,   32'h0,        32'hFFFF8001, 4'h0, 32'h0,  32'h0,        1'b1, 0};

    req_read = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_signed = 0;
    bus.avm_readdata = 0; bus.avm_waitrequest = 1;
    rst_n = 0;
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", bus.avm_address, 0);
    chk("rst_strobes", {30'd0, bus.avm_read, bus.avm_write}, 0);
    chk("rst_be", 32'(bus.avm_byteenable), 0);
    chk("rst_wdata", bus.avm_writedata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    foreach (tbl[i]) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].sz, tbl[i].sg,
             tbl[i].waits, tbl[i].rdv, r);
      chk($sformatf("tbl%0d_err", i), 32'(r.e), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_rdata", i), r.rdat, tbl[i].e_rdata);
      chk($sformatf("tbl%0d_strobes", i), r.nstrobe, tbl[i].e_strb);
      chk($sformatf("tbl%0d_cycles", i), r.ncyc, tbl[i].e_strb + 2);
      chk($sformatf("tbl%0d_stall", i), r.nstall, tbl[i].e_strb + 1);
      chk($sformatf("tbl%0d_done_pulse", i), 32'(r.done_after), 0);
      if (tbl[i].e_strb > 0) begin
        chk($sformatf("tbl%0d_be", i), 32'(r.be), 32'(tbl[i].e_be));
        chk($sformatf("tbl%0d_addr", i), r.ad, tbl[i].e_addr);
        if (tbl[i].wr) chk($sformatf("tbl%0d_wdata", i), r.wdo, tbl[i].e_wd);
      end
    end

    // Reset in the middle of a stalled write must drop the strobe at once.
    @(negedge clk);
    req_write = 1; req_addr = 32'h44; req_wdata = 32'h11223344; req_size = 2'd2;
    bus.avm_waitrequest = 1;
    repeat (3) @(negedge clk);
    chk("midrst_write_before", 32'(bus.avm_write), 1);
    rst_n = 0; req_write = 0;
    #1;
    chk("midrst_write", 32'(bus.avm_write), 0);
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1;
    access(1'b0, 1'b1, 32'h48, 32'h55667788, 2'd2, 1'b0, 1, 32'h0, r);
    chk("postrst_err", 32'(r.e), 0);
    chk("postrst_strobes", r.nstrobe, 2);
    chk("postrst_wdata", r.wdo, 32'h55667788);
    last_rd = 32'h0;

    for (int n = 0; n < 60; n++) begin
      logic rd, wr, sg;
      logic [31:0] a, wd, rdv;
      logic [1:0] sz;
      int waits, k;
      k = $urandom_range(0, 9);
      rd = (k <= 5); wr = (k == 0) || (k > 5);
      sz = 2'($urandom_range(0, 3));
      a = $urandom; wd = $urandom; rdv = $urandom;
      sg = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 10);
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      x = model(rd, wr, a, wd, sz, sg, waits, rdv);
      if (rd && !wr && x.legal && !x.err) last_rd = x.rd;
      access(rd, wr, a, wd, sz, sg, waits, rdv, r);
      chk($sformatf("rnd%0d_err", n), 32'(r.e), 32'(x.err));
      chk($sformatf("rnd%0d_rdata", n), r.rdat, last_rd);
      chk($sformatf("rnd%0d_strobes", n), r.nstrobe, x.strobes);
      chk($sformatf("rnd%0d_cycles", n), r.ncyc, x.strobes + 2);
      chk($sformatf("rnd%0d_done_pulse", n), 32'(r.done_after), 0);
      if (x.strobes > 0) begin
        chk($sformatf("rnd%0d_be", n), 32'(r.be), 32'(x.be));
        chk($sformatf("rnd%0d_addr", n), r.ad, x.addr);
        if (wr) chk($sformatf("rnd%0d_wdata", n), r.wdo, x.wd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
